// File: rtl/ex_fwd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_fwd_ctrl                                                |
// | Description : EX-stage operand forwarding and hazard controller for an   |
// |               in-order ID/EX/MEM/WB pipeline. Tracks the destination of  |
// |               the instructions in EX, MEM and WB. Produces registered     |
// |               operand-forwarding selects for the instruction entering EX. |
// |               Produces load-use stall/bubble requests. Freezes the whole   |
// |               pipe while a MEM-stage load waits for its data.             |
// | Config      : define FWD_WB_EN to forward from the WB stage. When it is   |
// |               undefined, the wb selects are tied low. A dependency on the |
// |               MEM-stage producer then stalls ID instead of forwarding.    |
// | Ports       : clk, rst (async, active high)                               |
// |               id_valid, id_rs1/2, id_rs1/2_used, id_rd, id_rd_wen,        |
// |               id_is_load : decoded info of the instruction in ID          |
// |               flush      : kill ID and EX (redirect)                      |
// |               lsu_rvalid : load data returned for the MEM-stage load      |
// |               exu_src*_forward_mem/wb : registered EX operand mux selects |
// |               id_stall, ex_bubble, pipe_hold : pipeline control           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ex_fwd_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rd_wen,
  input  logic       id_is_load,
  input  logic       flush,
  input  logic       lsu_rvalid,
  output logic       exu_src1_forward_mem,
  output logic       exu_src2_forward_mem,
  output logic       exu_src1_forward_wb,
  output logic       exu_src2_forward_wb,
  output logic       id_stall,
  output logic       ex_bubble,
  output logic       pipe_hold
);

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // Scoreboard slots
  logic       r_ex_valid;
  logic [4:0] r_ex_rd;
  logic       r_ex_wen;
  logic       r_ex_is_load;
  logic       r_mem_valid;
  logic [4:0] r_mem_rd;
  logic       r_mem_wen;
  logic       r_mem_is_load;
  logic       r_wb_valid;
  logic [4:0] r_wb_rd;
  logic       r_wb_wen;
  logic       r_wb_is_load;

  // A flush seen while the pipe is frozen is remembered until the next advancing edge.
  logic       r_flush_pend;

  logic       r_src1_fwd_mem;
  logic       r_src2_fwd_mem;

  logic       w_ex_prod;
  logic       w_mem_prod;
  logic       w_rs1_ex_hit;
  logic       w_rs2_ex_hit;
  logic       w_rs1_mem_hit;
  logic       w_rs2_mem_hit;
  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_hazard;
  logic       w_flush_eff;
  logic       w_hold;
  logic       w_issue;

  // A slot only produces a value when it actually writes a non-zero register.
  assign w_ex_prod  = r_ex_valid  & r_ex_wen  & (r_ex_rd  != 5'd0);
  assign w_mem_prod = r_mem_valid & r_mem_wen & (r_mem_rd != 5'd0);

  assign w_rs1_ex_hit  = id_rs1_used & w_ex_prod  & (r_ex_rd  == id_rs1);
  assign w_rs2_ex_hit  = id_rs2_used & w_ex_prod  & (r_ex_rd  == id_rs2);
  assign w_rs1_mem_hit = id_rs1_used & w_mem_prod & (r_mem_rd == id_rs1);
  assign w_rs2_mem_hit = id_rs2_used & w_mem_prod & (r_mem_rd == id_rs2);

  // The load result is not available until the load reaches WB.
  assign w_load_use = (w_rs1_ex_hit | w_rs2_ex_hit) & r_ex_is_load;

`ifdef FWD_WB_EN
  assign w_mem_stall = 1'b0;
`else
  // Without the WB path, the consumer waits in ID until the producer is in WB.
  // The register file write in WB is visible to the ID read in that cycle.
  // A younger EX match overrides the MEM match because EX holds the newer value.
  assign w_mem_stall = (w_rs1_mem_hit & ~w_rs1_ex_hit) |
                       (w_rs2_mem_hit & ~w_rs2_ex_hit);
`endif

  assign w_hazard    = id_valid & (w_load_use | w_mem_stall);
  assign w_flush_eff = flush | r_flush_pend;
  assign w_hold      = r_mem_valid & r_mem_is_load & ~lsu_rvalid;
  assign w_issue     = id_valid & ~w_hazard & ~w_flush_eff;

  // A flush kills the ID instruction, so stalling it would be pointless.
  // EX still takes a bubble.
  assign id_stall  = w_hazard & ~w_flush_eff;
  assign ex_bubble = w_hazard;
  assign pipe_hold = w_hold;

  // The load-wait FSM is bookkeeping. The hold output is purely combinational, so a
  // return in the same cycle never costs a hold cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:       if (w_hold)     w_state_nxt = ST_LOAD_WAIT;
      ST_LOAD_WAIT: if (lsu_rvalid) w_state_nxt = ST_RUN;
      default:                      w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= 5'd0;
      r_ex_wen       <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_mem_wen      <= 1'b0;
      r_mem_is_load  <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_wen       <= 1'b0;
      r_wb_is_load   <= 1'b0;
      r_flush_pend   <= 1'b0;
      r_src1_fwd_mem <= 1'b0;
      r_src2_fwd_mem <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold) begin
        if (flush) begin
          r_flush_pend <= 1'b1;
        end
      end else begin
        r_flush_pend   <= 1'b0;
        r_wb_valid     <= r_mem_valid;
        r_wb_rd        <= r_mem_rd;
        r_wb_wen       <= r_mem_wen;
        r_wb_is_load   <= r_mem_is_load;
        r_mem_valid    <= r_ex_valid;
        r_mem_rd       <= r_ex_rd;
        r_mem_wen      <= r_ex_wen;
        r_mem_is_load  <= r_ex_is_load;
        r_ex_valid     <= w_issue;
        r_ex_rd        <= w_issue ? id_rd : 5'd0;
        r_ex_wen       <= w_issue & id_rd_wen;
        r_ex_is_load   <= w_issue & id_is_load;
        // EX holds the youngest producer, so its match is the mem-side select.
        r_src1_fwd_mem <= w_issue & w_rs1_ex_hit;
        r_src2_fwd_mem <= w_issue & w_rs2_ex_hit;
      end
    end
  end

  assign exu_src1_forward_mem = r_src1_fwd_mem;
  assign exu_src2_forward_mem = r_src2_fwd_mem;

`ifdef FWD_WB_EN
  logic r_src1_fwd_wb;
  logic r_src2_fwd_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src1_fwd_wb <= 1'b0;
      r_src2_fwd_wb <= 1'b0;
    end else if (!w_hold) begin
      // MEM priority: a hit on the younger EX slot suppresses the older MEM hit.
      r_src1_fwd_wb <= w_issue & w_rs1_mem_hit & ~w_rs1_ex_hit;
      r_src2_fwd_wb <= w_issue & w_rs2_mem_hit & ~w_rs2_ex_hit;
    end
  end

  assign exu_src1_forward_wb = r_src1_fwd_wb;
  assign exu_src2_forward_wb = r_src2_fwd_wb;
`else
  assign exu_src1_forward_wb = 1'b0;
  assign exu_src2_forward_wb = 1'b0;
`endif

  // The WB slot is retained for debug visibility. No control decision in this block reads it.
  logic w_unused_wb;
  assign w_unused_wb = ^{r_wb_valid, r_wb_rd, r_wb_wen, r_wb_is_load};

endmodule
`default_nettype wire

// File: tb/tb_ex_fwd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ex_fwd_ctrl                                             |
// | Description : Self-checking bench for ex_fwd_ctrl. The bench tracks which |
// |               instructions are in flight and derives the hazard and       |
// |               forwarding outcome from the distance to the youngest writer |
// |               of each source. A monitor compares the expectations against  |
// |               the DUT outputs.                                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ex_fwd_ctrl;

`ifdef FWD_WB_EN
  localparam bit WB_FWD = 1'b1;
`else
  localparam bit WB_FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd = 5'd0;
  logic       id_rd_wen = 1'b0;
  logic       id_is_load = 1'b0;
  logic       flush = 1'b0;
  logic       lsu_rvalid = 1'b0;
  logic       exu_src1_forward_mem;
  logic       exu_src2_forward_mem;
  logic       exu_src1_forward_wb;
  logic       exu_src2_forward_wb;
  logic       id_stall;
  logic       ex_bubble;
  logic       pipe_hold;

  always #5 clk = ~clk;

  ex_fwd_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_valid             (id_valid),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .id_rs1_used          (id_rs1_used),
    .id_rs2_used          (id_rs2_used),
    .id_rd                (id_rd),
    .id_rd_wen            (id_rd_wen),
    .id_is_load           (id_is_load),
    .flush                (flush),
    .lsu_rvalid           (lsu_rvalid),
    .exu_src1_forward_mem (exu_src1_forward_mem),
    .exu_src2_forward_mem (exu_src2_forward_mem),
    .exu_src1_forward_wb  (exu_src1_forward_wb),
    .exu_src2_forward_wb  (exu_src2_forward_wb),
    .id_stall             (id_stall),
    .ex_bubble            (ex_bubble),
    .pipe_hold            (pipe_hold)
  );

  // In-flight instructions: index 0 is the youngest (EX), 1 is MEM, 2 is WB.
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       wen;
    bit       ld;
  } ins_t;

  typedef struct packed {
    bit [3:0] sel;   // {src1_mem, src2_mem, src1_wb, src2_wb}
    bit       stall;
    bit       bub;
    bit       hold;
  } exp_t;

  ins_t     pipe [3];
  bit [3:0] m_sel;
  bit       m_pend;
  exp_t     q[$];
  int       total = 0;
  int       bad   = 0;

  function automatic void reset_model();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_sel  = 4'd0;
    m_pend = 1'b0;
  endfunction

  // 0: no dependency, 1: take from EX-stage producer, 2: take from MEM-stage
  // producer, 3: value not obtainable yet (stall).
  function automatic int classify(bit used, bit [4:0] r);
    if (!used || r == 5'd0) return 0;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].v && pipe[k].wen && pipe[k].rd == r) begin
        if (k == 0) return pipe[k].ld ? 3 : 1;
        return WB_FWD ? 2 : 3;
      end
    end
    return 0;
  endfunction

  function automatic bit model_hazard();
    int c1 = classify(id_rs1_used, id_rs1);
    int c2 = classify(id_rs2_used, id_rs2);
    return id_valid && (c1 == 3 || c2 == 3);
  endfunction

  // Applies one clock edge to the model, using the inputs held before that edge.
  function automatic void model_edge();
    bit hold, fl, issue;
    int c1, c2;
    if (rst) begin
      reset_model();
      return;
    end
    hold = pipe[1].v && pipe[1].ld && !lsu_rvalid;
    if (hold) begin
      if (flush) m_pend = 1'b1;
      return;
    end
    fl    = flush || m_pend;
    c1    = classify(id_rs1_used, id_rs1);
    c2    = classify(id_rs2_used, id_rs2);
    issue = id_valid && !model_hazard() && !fl;
    m_sel = issue ? {c1 == 1, c2 == 1, c1 == 2, c2 == 2} : 4'd0;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = issue ? {1'b1, id_rd, id_rd_wen, id_is_load} : '0;
    m_pend = 1'b0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    bit   hz;
    if (rst) reset_model();
    hz      = model_hazard();
    e.sel   = m_sel;
    e.stall = hz && !(flush || m_pend);
    e.bub   = hz;
    e.hold  = pipe[1].v && pipe[1].ld && !lsu_rvalid;
    q.push_back(e);
  endfunction

  task automatic step(input bit r, input bit v, input bit [4:0] a, input bit ua,
                      input bit [4:0] b, input bit ub, input bit [4:0] d,
                      input bit w, input bit l, input bit f, input bit rv);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; id_valid = v; id_rs1 = a; id_rs1_used = ua; id_rs2 = b;
    id_rs2_used = ub; id_rd = d; id_rd_wen = w; id_is_load = l;
    flush = f; lsu_rvalid = rv;
    push_exp();
  endtask

  task automatic nop(input bit rv);
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rv);
  endtask

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: the outputs are presented every cycle, so one expectation is popped per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("selects", {exu_src1_forward_mem, exu_src2_forward_mem,
                          exu_src1_forward_wb, exu_src2_forward_wb}, e.sel);
        check("id_stall",  {3'd0, id_stall},  {3'd0, e.stall});
        check("ex_bubble", {3'd0, ex_bubble}, {3'd0, e.bub});
        check("pipe_hold", {3'd0, pipe_hold}, {3'd0, e.hold});
      end
    end
  end

  initial begin
    int guard;
    reset_model();
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // add x5 ; add x6,x5,x1
    step(0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 1);
    step(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
    nop(1); nop(1); nop(1);
    // add x5 ; nop ; sub x7,x1,x5 (held two cycles in case ID stalls)
    step(0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 1);
    nop(1);
    step(0, 1, 1, 1, 5, 1, 7, 1, 0, 0, 1);
    step(0, 1, 1, 1, 5, 1, 7, 1, 0, 0, 1);
    nop(1); nop(1); nop(1);
    // ld x8 ; add x9,x8,x8 presented until it gets through
    step(0, 1, 1, 1, 0, 0, 8, 1, 1, 0, 1);
    step(0, 1, 8, 1, 8, 1, 9, 1, 0, 0, 1);
    step(0, 1, 8, 1, 8, 1, 9, 1, 0, 0, 1);
    step(0, 1, 8, 1, 8, 1, 9, 1, 0, 0, 1);
    nop(1); nop(1); nop(1);
    // ld x10, data late by three cycles
    step(0, 1, 1, 1, 0, 0, 10, 1, 1, 0, 1);
    nop(1);
    step(0, 1, 10, 1, 0, 0, 12, 1, 0, 0, 0);
    step(0, 1, 10, 1, 0, 0, 12, 1, 0, 0, 0);
    step(0, 1, 10, 1, 0, 0, 12, 1, 0, 1, 0);
    step(0, 1, 10, 1, 0, 0, 12, 1, 0, 0, 1);
    nop(1); nop(1); nop(1);
    // x0 writes then reads
    step(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1, 3, 1, 0, 0, 1);
    nop(1); nop(1);
    // load-use together with flush
    step(0, 1, 1, 1, 0, 0, 3, 1, 1, 0, 1);
    step(0, 1, 3, 1, 0, 0, 4, 1, 0, 1, 1);
    nop(1); nop(1); nop(1);
    // reset in the middle of a load wait, data arrives after reset
    step(0, 1, 1, 1, 0, 0, 11, 1, 1, 0, 1);
    nop(1);
    nop(0); nop(0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 11, 1, 0, 0, 13, 1, 0, 0, 1);
    nop(1); nop(1);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 200) == 0, ($urandom % 4) != 0,
           5'($urandom_range(0, 7)), ($urandom % 4) != 0,
           5'($urandom_range(0, 7)), ($urandom % 2) != 0,
           5'($urandom_range(0, 7)), ($urandom % 5) != 0,
           ($urandom % 10) < 3, ($urandom % 12) == 0,
           ($urandom % 4) != 0);
    end
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain remaining=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
